ieee_to_int: RTL
================

IEEE_TO_INT -- requirements
Module: ieee_to_int

Interface
REQ-001 The block SHALL expose these ports: clk, input, 1 bit, single clock; all state is updated on its rising edge.
REQ-002 The block SHALL expose these ports: rst_n, input, 1 bit, asynchronous, active-low reset.
REQ-003 The block SHALL expose these ports: in_float, input, 32 bits, IEEE-754 single-precision operand.
REQ-004 The block SHALL expose these ports: in_valid (input, 1) and in_ready (output, 1); together they form the operand handshake.
REQ-005 The block SHALL expose these ports: out_int, output, 5 bits, unsigned integer part of the magnitude.
REQ-006 The block SHALL expose these ports: out_frac, output, 5 bits, first five fraction bits of the magnitude (Q5.5 together with out_int).
REQ-007 The block SHALL expose these ports: out_sign, out_ovf, out_unf and out_nan, each an output of 1 bit; they flag sign, overflow, underflow and NaN.
REQ-008 The block SHALL expose these ports: out_valid (output, 1) and out_ready (input, 1); together they form the result handshake.

Function
REQ-009 The block SHALL convert the float to a Q5.5 unsigned magnitude plus a sign bit; it is the decoding counterpart of the team's 5-bit-integer-to-IEEE encoder.
REQ-010 The block SHALL implement an FSM with states IDLE, ALIGN and DONE; in_ready SHALL be 1 only in IDLE.
REQ-011 When in_valid and in_ready are both 1 at an edge, the block SHALL capture the operand and do the following:
- Load acc = {1, mantissa[22:0]} (24 bits).
- Load E = exp-127.
- Load cnt = 18-E.
- Move to ALIGN.
REQ-012 Each cycle in ALIGN, the block SHALL do the following:
- Shift acc right by 1.
- Record the shifted-out bit as the guard bit and OR the previous guard bit into the sticky bit.
- Decrement cnt.
- When cnt reaches 0, move to DONE with {out_int,out_frac} = acc[9:0].
REQ-013 For normal values with E in [-5,4], latency from accept edge N SHALL be cnt+1: out_valid rises at edge N+19-E, which is 15 to 24 cycles.
REQ-014 The following special cases SHALL bypass ALIGN and go IDLE->DONE, with out_valid at edge N+1:
- exp=0 (zero or denormal): result 0, all flags 0.
- exp=255 with mantissa≠0: out_nan=1, result 0.
- exp=255 with mantissa=0 (infinity): out_ovf=1, result all ones.
- E>4: out_ovf=1, result saturated to 31.31 (10'h3FF).
- E<-5: result 0, out_unf=1.
REQ-015 out_sign SHALL equal in_float[31] for every operand, NaN included; the magnitude SHALL NOT be negated.
REQ-016 In DONE, out_valid SHALL be 1 and all outputs SHALL hold stable until out_ready=1.
REQ-017 When out_ready=1 in DONE, the block SHALL return to IDLE on the next edge; there is no bypass, so an operand is accepted at the earliest one cycle after the result is taken.
REQ-018 The block SHALL NOT start a new conversion while in ALIGN or DONE; in_float and in_valid are ignored in those states.
REQ-019 out_ready in IDLE or ALIGN SHALL have no effect.

Reset
REQ-020 When rst_n=0, the block SHALL immediately do the following regardless of clk:
- Force the FSM to IDLE.
- Set acc, cnt, guard and sticky to 0.
- Set out_int, out_frac and all flags to 0.
- Set out_valid to 0; in_ready becomes 1.
REQ-021 A reset during ALIGN or DONE SHALL discard the conversion in progress; no out_valid is produced for it.
REQ-022 After rst_n rises, the first rising edge of clk with in_valid=1 SHALL accept an operand.

Configuration
REQ-023 With IEEE_TO_INT_ROUND_EN defined, entry to DONE from ALIGN SHALL round acc[9:0] to nearest-even:
- Round up when guard=1 and (sticky=1 or acc[0]=1).
- If rounding carries past 31.31, saturate to 10'h3FF and set out_ovf=1.
- The latency of REQ-013 is unchanged.
REQ-024 Without IEEE_TO_INT_ROUND_EN, the result SHALL be truncated and guard/sticky logic SHALL NOT be synthesised.
REQ-025 The underflow path (E<-5) SHALL always produce zero, in both builds.

Verification
REQ-026 0x40E00000 (7.0) accepted at edge N -> out_valid at N+17; out_int=7, out_frac=0, all flags 0.
REQ-027 0xC0D00000 (-6.5) -> out_int=6, out_frac=16, out_sign=1.
REQ-028 0x3D000000 (2^-5) -> out_valid at N+24; out_frac=1. 0x3C800000 (2^-6) -> out_valid at N+1; result 0, out_unf=1.
REQ-029 0x42000000 (32.0) -> out_ovf=1, result 10'h3FF at N+1. 0x7FC00000 -> out_nan=1 at N+1.
REQ-030 0x3D400000 (1.5x2^-5) -> out_frac=1 with truncation; out_frac=2 with IEEE_TO_INT_ROUND_EN.
REQ-031 Scenario: rst_n pulsed low mid-ALIGN, then out_ready held 0 for 5 cycles in DONE. Required response:
- After the reset: out_valid never asserts for the aborted operand and in_ready=1 immediately.
- With out_ready held 0 in DONE: outputs stay stable and in_ready stays 0.

Source files
------------

// File: rtl/ieee_to_int.sv
// IEEE-754 single-precision to Q5.5 sign/magnitude converter, aligned one bit per cycle.
// Define IEEE_TO_INT_ROUND_EN to round to nearest-even instead of truncating.
module ieee_to_int (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_float,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [4:0]  out_int,
  output logic [4:0]  out_frac,
  output logic        out_sign,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        out_nan,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, ALIGN, DONE} state_t;

  state_t       state_q, state_d;
  logic [23:0]  acc_q, acc_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [9:0]   result_q, result_d;
  logic         sign_q, sign_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;
  logic         nan_q, nan_d;
`ifdef IEEE_TO_INT_ROUND_EN
  logic         guard_q, guard_d;
  logic         sticky_q, sticky_d;
  logic [10:0]  rounded;

  // Returns {ovf, value}; a carry out of 31.31 saturates.
  function automatic logic [10:0] round_ne(input logic [9:0] v, input logic g,
                                           input logic s);
    logic [10:0] sum;
    sum = {1'b0, v} + {10'd0, g & (s | v[0])};
    if (sum[10]) round_ne = {1'b1, 10'h3FF};
    else         round_ne = {1'b0, sum[9:0]};
  endfunction
`endif

  logic [7:0]         exp_w;
  logic [22:0]        mant_w;
  logic signed [9:0]  e_s;

  assign exp_w  = in_float[30:23];
  assign mant_w = in_float[22:0];
  assign e_s    = $signed({2'b00, exp_w}) - 10'sd127;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    nan_d    = nan_q;
`ifdef IEEE_TO_INT_ROUND_EN
    guard_d  = guard_q;
    sticky_d = sticky_q;
    rounded  = round_ne(acc_q[9:0], guard_q, sticky_q);
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d   = in_float[31];
          result_d = 10'd0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          nan_d    = 1'b0;
          state_d  = DONE;
          if (exp_w == 8'd0) begin
            result_d = 10'd0;
          end else if (exp_w == 8'hFF) begin
            if (mant_w != 23'd0) nan_d = 1'b1;
            else begin
              ovf_d    = 1'b1;
              result_d = 10'h3FF;
            end
          end else if (e_s > 10'sd4) begin
            ovf_d    = 1'b1;
            result_d = 10'h3FF;
          end else if (e_s < -10'sd5) begin
            unf_d = 1'b1;
          end else begin
            // cnt = 18 - E = 145 - exp, always within 14..23 here.
            acc_d   = {1'b1, mant_w};
            cnt_d   = 5'(8'd145 - exp_w);
            state_d = ALIGN;
`ifdef IEEE_TO_INT_ROUND_EN
            guard_d  = 1'b0;
            sticky_d = 1'b0;
`endif
          end
        end
      end
      ALIGN: begin
        if (cnt_q == 5'd0) begin
          state_d = DONE;
`ifdef IEEE_TO_INT_ROUND_EN
          result_d = rounded[9:0];
          ovf_d    = rounded[10];
`else
          result_d = acc_q[9:0];
`endif
        end else begin
          acc_d = acc_q >> 1;
          cnt_d = cnt_q - 5'd1;
`ifdef IEEE_TO_INT_ROUND_EN
          guard_d  = acc_q[0];
          sticky_d = sticky_q | guard_q;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= 24'd0;
      cnt_q    <= 5'd0;
      result_q <= 10'd0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      nan_q    <= 1'b0;
`ifdef IEEE_TO_INT_ROUND_EN
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      nan_q    <= nan_d;
`ifdef IEEE_TO_INT_ROUND_EN
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_int   = result_q[9:5];
  assign out_frac  = result_q[4:0];
  assign out_sign  = sign_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;
  assign out_nan   = nan_q;

endmodule
